// File: rtl/deconvolution.sv
// Sequential mod-16 deconvolver: recovers 8 input samples from a 16-lane convolution output
// and an 8-tap kernel by forward substitution, one MAC per cycle. Define DECONV_CHECK_EN to add upper-lane checking.
module deconvolution (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] y_in,
    input  logic [31:0] h_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic        err,
    output logic        check_err
);

    typedef enum logic [2:0] {S_IDLE, S_INV, S_SOLVE, S_CHECK, S_DONE} state_t;

    function automatic logic [3:0] mul4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'd0, a} * {4'd0, b};
        return p[3:0];
    endfunction

    state_t      state_q;
    logic [3:0]  y_q [16];
    logic [3:0]  h_q [8];
    logic [3:0]  x_q [8];
    logic [3:0]  hinv_q;
    logic [3:0]  acc_q;
    logic [3:0]  row_q;
    logic [3:0]  tap_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] x_out_q;
`ifdef DECONV_CHECK_EN
    logic        check_err_q;
`endif

    logic [2:0]  idx_d;
    logic [3:0]  prod_d;
    logic [3:0]  xnew_d;
    logic [3:0]  hinv_d;
    logic [31:0] x_pack_d;

    // One shared multiplier: x[row-tap]*h[tap] serves both the solve and check passes.
    always_comb begin
        idx_d  = 3'(row_q - tap_q);
        prod_d = mul4(x_q[idx_d], h_q[tap_q[2:0]]);
        xnew_d = mul4(acc_q, hinv_q);
        hinv_d = mul4(mul4(h_q[0], h_q[0]), h_q[0]);
        x_pack_d = '0;
        for (int k = 0; k < 8; k++) begin
            x_pack_d[k*4 +: 4] = x_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 16; i++) y_q[i] <= '0;
            for (int j = 0; j < 8; j++) begin
                h_q[j] <= '0;
                x_q[j] <= '0;
            end
            hinv_q  <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            tap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            x_out_q <= '0;
`ifdef DECONV_CHECK_EN
            check_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) y_q[i] <= y_in[i*4 +: 4];
                        for (int j = 0; j < 8; j++) h_q[j] <= h_in[j*4 +: 4];
                        err_q   <= 1'b0;
`ifdef DECONV_CHECK_EN
                        check_err_q <= 1'b0;
`endif
                        busy_q  <= 1'b1;
                        state_q <= S_INV;
                    end
                end
                S_INV: begin
                    if (h_q[0][0]) begin
                        // Odd units mod 16 have order dividing 4, so h0^3 is the inverse.
                        hinv_q  <= hinv_d;
                        acc_q   <= y_q[0];
                        row_q   <= 4'd0;
                        tap_q   <= 4'd1;
                        state_q <= S_SOLVE;
                    end else begin
                        err_q   <= 1'b1;
                        x_out_q <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_SOLVE: begin
                    if (tap_q <= row_q) begin
                        acc_q <= acc_q - prod_d;
                        tap_q <= tap_q + 4'd1;
                    end else begin
                        x_q[row_q[2:0]] <= xnew_d;
                        if (row_q == 4'd7) begin
`ifdef DECONV_CHECK_EN
                            row_q   <= 4'd8;
                            tap_q   <= 4'd1;
                            acc_q   <= '0;
                            state_q <= S_CHECK;
`else
                            x_out_q <= {xnew_d, x_pack_d[27:0]};
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
`endif
                        end else begin
                            row_q <= row_q + 4'd1;
                            tap_q <= 4'd1;
                            acc_q <= y_q[row_q + 4'd1];
                        end
                    end
                end
`ifdef DECONV_CHECK_EN
                S_CHECK: begin
                    if (tap_q <= 4'd7) begin
                        acc_q <= acc_q + prod_d;
                        tap_q <= tap_q + 4'd1;
                    end else begin
                        if (acc_q != y_q[row_q]) check_err_q <= 1'b1;
                        if (row_q == 4'd15) begin
                            x_out_q <= x_pack_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            // Next row i+1 starts at tap (i+1)-7.
                            row_q <= row_q + 4'd1;
                            tap_q <= row_q - 4'd6;
                            acc_q <= '0;
                        end
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_out = x_out_q;
    assign err   = err_q;
`ifdef DECONV_CHECK_EN
    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_deconvolution.sv
// Scoreboard bench for deconvolution: expected results queued at start, compared on done.
module tb_deconvolution;

`ifdef DECONV_CHECK_EN
    localparam int LAT    = 74;
    localparam bit CHK_ON = 1'b1;
`else
    localparam int LAT    = 38;
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] y_in = '0;
    logic [31:0] h_in = '0;
    logic        busy, done, err, check_err;
    logic [31:0] x_out;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] x;
        logic        e;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    deconvolution dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in), .h_in(h_in),
        .busy(busy), .done(done), .x_out(x_out), .err(err), .check_err(check_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Forward convolution: y[i] = sum x[i-j]*h[j] mod 16.
    function automatic logic [63:0] conv(input logic [31:0] x, input logic [31:0] h);
        logic [63:0] y;
        logic [3:0]  s;
        logic [7:0]  p;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            s = '0;
            for (int j = 0; j < 8; j++) begin
                if (i - j >= 0 && i - j <= 7) begin
                    p = {4'd0, x[(i-j)*4 +: 4]} * {4'd0, h[j*4 +: 4]};
                    s = s + p[3:0];
                end
            end
            y[i*4 +: 4] = s;
        end
        return y;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("x_out", x_out, e.x);
                chk("err", err, e.e);
                chk("check_err", check_err, e.c);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic run_op(input logic [63:0] y, input logic [31:0] h, input logic [31:0] ex,
                          input logic ee, input logic ec, input int lat);
        exp_t e;
        @(posedge clk); #1;
        y_in = y; h_in = h; start = 1'b1;
        e.x = ex; e.e = ee; e.c = ec; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        y_in = ~y; h_in = ~h;
        @(negedge clk);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_x_out"}, x_out, 32'h0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_check_err"}, check_err, 1'b0);
    endtask

    initial begin
        logic [31:0] rx, rh;
        int          a0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        run_op(64'h0000_0000_8765_4321, 32'h0000_0001, 32'h8765_4321, 1'b0, 1'b0, LAT);
        wait_idle(200);
        run_op(64'h0000_0001_2222_2221, 32'h0000_0011, 32'h1111_1111, 1'b0, 1'b0, LAT);
        wait_idle(200);
        run_op(64'h0000_0000_3333_3333, 32'h0000_0003, 32'h1111_1111, 1'b0, 1'b0, LAT);
        wait_idle(200);
        run_op(64'h0123_4567_89ab_cdef, 32'h0000_0012, 32'h0, 1'b1, 1'b0, 2);
        wait_idle(200);
        run_op(64'h0000_0002_2222_2221, 32'h0000_0011, 32'h1111_1111, 1'b0, CHK_ON, LAT);
        wait_idle(200);
        // Back-to-back after an error and after a check failure: flags must clear on accept.
        run_op(64'h0000_0000_8765_4321, 32'h0000_0001, 32'h8765_4321, 1'b0, 1'b0, LAT);
        wait_idle(200);

        for (int n = 0; n < 8; n++) begin
            rx = $urandom;
            rh = $urandom;
            rh[0] = 1'b1;
            if (n == 0) rh = {28'h0, rh[3:0]};
            if (n == 1) rh = 32'hFFFF_FFFF;
            run_op(conv(rx, rh), rh, rx, 1'b0, 1'b0, LAT);
            wait_idle(200);
        end

        // Start pulsed mid-operation must be ignored.
        rx = 32'hA5C3_1E70; rh = 32'h3579_BDF5;
        run_op(conv(rx, rh), rh, rx, 1'b0, 1'b0, LAT);
        a0 = cyc;
        while (cyc < a0 + 8) @(posedge clk);
        #1 start = 1'b1; y_in = 64'h1; h_in = 32'h1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(200);
        repeat (90) @(posedge clk);

        // Reset mid-operation aborts with no done.
        rx = 32'h1357_9BDF; rh = 32'h0000_0F07;
        run_op(conv(rx, rh), rh, rx, 1'b0, 1'b0, LAT);
        a0 = cyc;
        while (cyc < a0 + 18) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (90) @(posedge clk);

        // Reset and start together: reset wins.
        #1 rst = 1'b1; start = 1'b1; y_in = 64'h1; h_in = 32'h1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_start");

        rx = 32'hFEDC_BA98; rh = 32'h2468_ACE1;
        run_op(conv(rx, rh), rh, rx, 1'b0, 1'b0, LAT);
        wait_idle(200);
        repeat (20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
